// File: rtl/expr_seq_pkg.sv
// -----------------------------------------------------------------------------
// expr_seq_pkg
// Shared types and control-word field helpers for the expression-solver
// control sequencer.
//
// Control word layout, LSB first:
//   [0]                     last  : terminating step
//   [N_MUX*SEL_W:1]         sel   : mux i at [i*SEL_W+1 +: SEL_W]
//   [N_MUX*SEL_W+1]         op    : ALU operation select
//   [CW-1 -: N_LOAD]        load  : register-load strobes
// -----------------------------------------------------------------------------
package expr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int LAST_POS = 0;
  localparam int SEL_LSB  = 1;

  function automatic int op_pos(input int n_mux, input int sel_w);
    return n_mux * sel_w + 1;
  endfunction

  function automatic int load_lsb(input int n_mux, input int sel_w);
    return n_mux * sel_w + 2;
  endfunction

endpackage

// File: rtl/expr_step_table.sv
// -----------------------------------------------------------------------------
// expr_step_table
// N_STEPS x CW control-word table: one synchronous write port, one
// combinational read port, cleared to zero by reset.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears every word)
//   we        : write strobe (already qualified by the caller's state)
//   wr_addr   : write address; addresses >= N_STEPS are dropped here
//   wr_data   : word to write
//   rd_addr   : read address (caller keeps it below N_STEPS)
//   rd_data   : word at rd_addr
// -----------------------------------------------------------------------------
module expr_step_table #(
  parameter  int N_STEPS = 7,
  parameter  int CW      = 11,
  localparam int AW      = $clog2(N_STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  localparam logic [AW-1:0] ADDR_MAX = AW'(N_STEPS - 1);

  logic [CW-1:0] mem_q [N_STEPS];
  logic          wr_ok;

  assign wr_ok = we && (wr_addr <= ADDR_MAX);

  // NOTE: this array is reset on purpose -- an unprogrammed or reset table
  // must read back as all-zero words, so it stays in flops rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STEPS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/expr_sequencer.sv
// -----------------------------------------------------------------------------
// expr_sequencer
// Programmable control sequencer for the expression-solver datapath. On an
// accepted start it plays table words 0..k onto registered control outputs,
// one per cycle, stopping after a word with last=1 or after word N_STEPS-1,
// then pulses done for one cycle and returns to IDLE.
//
// Build option:
//   SEQ_HOLD_EN : when defined, hold=1 in RUN freezes the step and keeps the
//                 current op/sel with load forced to 0. When undefined, the
//                 hold input is present but has no effect.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : run request, honoured only in IDLE
//   prog_we    : table write strobe (IDLE only, prog_addr < N_STEPS)
//   prog_addr  : table write address
//   prog_data  : control word to write
//   hold       : stall request (see SEQ_HOLD_EN)
//   load       : register-load strobes
//   op         : ALU operation select
//   sel        : packed mux selects
//   busy       : high while in RUN
//   done       : one-cycle completion pulse
// -----------------------------------------------------------------------------
module expr_sequencer
  import expr_seq_pkg::*;
#(
  parameter  int N_STEPS = 7,
  parameter  int N_LOAD  = 3,
  parameter  int N_MUX   = 3,
  parameter  int SEL_W   = 2,
  localparam int AW      = $clog2(N_STEPS),
  localparam int CW      = N_LOAD + 1 + N_MUX * SEL_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [AW-1:0]          prog_addr,
  input  logic [CW-1:0]          prog_data,
  input  logic                   hold,
  output logic [N_LOAD-1:0]      load,
  output logic                   op,
  output logic [N_MUX*SEL_W-1:0] sel,
  output logic                   busy,
  output logic                   done
);

  localparam int              SW       = N_MUX * SEL_W;
  localparam int              OP_POS   = op_pos(N_MUX, SEL_W);
  localparam int              LOAD_LSB = load_lsb(N_MUX, SEL_W);
  localparam logic [AW-1:0]   STEP_MAX = AW'(N_STEPS - 1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [N_LOAD-1:0] load_q, load_d;
  logic              op_q, op_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     rd_word;
  logic              hold_eff;

`ifdef SEQ_HOLD_EN
  assign hold_eff = hold;
`else
  // Port kept for a uniform interface; tied off so RUN always advances.
  assign hold_eff = hold & 1'b0;
`endif

  expr_step_table #(
    .N_STEPS (N_STEPS),
    .CW      (CW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (prog_we && (state_q == IDLE)),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  // The table is read one step ahead: in IDLE it presents word 0 for the
  // start edge, in RUN the word that follows the one on the outputs.
  always_comb begin
    rd_addr = '0;
    if (state_q == RUN && step_q != STEP_MAX) rd_addr = step_q + AW'(1);
  end

  // NOTE: combinational next-state logic uses blocking assignments and
  // gives every output a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    load_d  = '0;
    op_d    = 1'b0;
    sel_d   = '0;
    last_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          step_d  = '0;
          load_d  = rd_word[LOAD_LSB +: N_LOAD];
          op_d    = rd_word[OP_POS];
          sel_d   = rd_word[SEL_LSB +: SW];
          last_d  = rd_word[LAST_POS];
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (hold_eff) begin
          // Stalled: keep the word but suppress register reloads.
          op_d   = op_q;
          sel_d  = sel_q;
          last_d = last_q;
          busy_d = 1'b1;
        end else if (last_q || step_q == STEP_MAX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + AW'(1);
          load_d = rd_word[LOAD_LSB +: N_LOAD];
          op_d   = rd_word[OP_POS];
          sel_d  = rd_word[SEL_LSB +: SW];
          last_d = rd_word[LAST_POS];
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      load_q  <= '0;
      op_q    <= 1'b0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      load_q  <= load_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load = load_q;
  assign op   = op_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_expr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_expr_sequencer
// Directed bench for expr_sequencer at default parameters. Output bundle
// compared every cycle is {load[2:0], op, sel[5:0], busy, done}.
// Stall checks follow SEQ_HOLD_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_expr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [10:0] prog_data;
  logic        hold;
  logic [2:0]  load;
  logic        op;
  logic [5:0]  sel;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  expr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .hold      (hold),
    .load      (load),
    .op        (op),
    .sel       (sel),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout {load[2:0], op, sel[5:0], last}; expected fields split by hand.
  typedef struct {
    logic [10:0] word;
    logic [2:0]  exp_load;
    logic        exp_op;
    logic [5:0]  exp_sel;
  } vec_t;

  vec_t vecs [7];

  localparam logic [11:0] EXP_DONE = 12'b000_0_000000_0_1;
  localparam logic [11:0] EXP_IDLE = 12'b000_0_000000_0_0;
  localparam logic [11:0] EXP_ZERO = 12'b000_0_000000_1_0;

  function automatic logic [11:0] outs();
    return {load, op, sel, busy, done};
  endfunction

  function automatic logic [11:0] exp_run(input int k, input bit no_load);
    logic [2:0] l;
    l = no_load ? 3'b000 : vecs[k].exp_load;
    return {l, vecs[k].exp_op, vecs[k].exp_sel, 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [2:0] addr, input logic [10:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic prog_all();
    for (int i = 0; i < 7; i++) prog(3'(i), vecs[i].word);
  endtask

  // Full 7-step run: words on cycles 1..7, done at 8, idle at 9.
  task automatic run_seq(input string tag, input bit zero_tbl);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s_step%0d", tag, k), outs(), zero_tbl ? EXP_ZERO : exp_run(k, 1'b0));
      tick();
    end
    check($sformatf("%s_done", tag), outs(), EXP_DONE);
    tick();
    check($sformatf("%s_idle", tag), outs(), EXP_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bd_exp [10];
    int         hold_idx [];
    bit         hold_nl  [];

    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    hold      = 1'b0;

    vecs[0] = '{word: 11'h102, exp_load: 3'b001, exp_op: 1'b0, exp_sel: 6'h01};
    vecs[1] = '{word: 11'h2A4, exp_load: 3'b010, exp_op: 1'b1, exp_sel: 6'h12};
    vecs[2] = '{word: 11'h47E, exp_load: 3'b100, exp_op: 1'b0, exp_sel: 6'h3F};
    vecs[3] = '{word: 11'h0C8, exp_load: 3'b000, exp_op: 1'b1, exp_sel: 6'h24};
    vecs[4] = '{word: 11'h780, exp_load: 3'b111, exp_op: 1'b1, exp_sel: 6'h00};
    vecs[5] = '{word: 11'h32A, exp_load: 3'b011, exp_op: 1'b0, exp_sel: 6'h15};
    vecs[6] = '{word: 11'h5D5, exp_load: 3'b101, exp_op: 1'b1, exp_sel: 6'h2A};

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    check("in_reset", outs(), EXP_IDLE);
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("idle_c%0d", c), outs(), EXP_IDLE);
    end

    // Full sequence, last only on word 6.
    prog_all();
    run_seq("full", 1'b0);

    // Word 2 terminates; start held high: restart 5 cycles after the first.
    prog(3'd2, 11'h47F);
    bd_exp = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("short_c%0d", c), {busy, done}, bd_exp[c-1]);
      if (c == 3) check("short_last_word", outs(), {vecs[2].exp_load, vecs[2].exp_op, vecs[2].exp_sel, 2'b10});
      if (c == 6) check("short_restart_word0", outs(), exp_run(0, 1'b0));
    end
    start = 1'b0;
    prog(3'd2, vecs[2].word);

    // Write during RUN to addr 5 and write to addr 7 in IDLE are both dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    prog_we   = 1'b1;
    prog_addr = 3'd5;
    prog_data = 11'h000;
    tick();
    prog_we = 1'b0;
    repeat (5) tick();
    check("drop_run_done", outs(), EXP_DONE);
    tick();
    prog(3'd7, 11'h7FF);
    run_seq("readback", 1'b0);

    // Reset at cycle 3 of a run clears outputs at once and the table.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_word2", outs(), exp_run(2, 1'b0));
    rst = 1'b1;
    #1;
    check("rst_mid_run", outs(), EXP_IDLE);
    tick();
    #2 rst = 1'b0;
    tick();
    check("post_rst_idle", outs(), EXP_IDLE);
    run_seq("zero", 1'b1);

    // Hold for two cycles at step 2.
    prog_all();
`ifdef SEQ_HOLD_EN
    hold_idx = '{0, 1, 2, 2, 2, 3, 4, 5, 6};
    hold_nl  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
`else
    hold_idx = '{0, 1, 2, 3, 4, 5, 6};
    hold_nl  = '{0, 0, 0, 0, 0, 0, 0};
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= hold_idx.size(); c++) begin
      check($sformatf("hold_c%0d", c), outs(), exp_run(hold_idx[c-1], hold_nl[c-1]));
      hold = (c == 3 || c == 4);
      tick();
    end
    hold = 1'b0;
    check("hold_done", outs(), EXP_DONE);
    tick();
    check("hold_idle", outs(), EXP_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
